// File: rtl/shift_frame_controller.sv
`timescale 1ns/1ps
// Frame sequencer for a free-running serial shift register: serializes a word LSB-first,
// waits out the register latency and recovers it. Optional parity: define SERIAL_PARITY_EN.
//
// state | meaning
// IDLE  | txReady high, waiting for txValid
// SHIFT | driving frame bits onto serOut, capture may already run if LAT < NB
// DRAIN | serOut low, capturing the remaining returning bits
// DONE  | publish rxData with a one-cycle rxValid
module shift_frame_controller #(
  parameter int WIDTH = 8,
  parameter int LAT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] txData,
  input  logic             txValid,
  output logic             txReady,
  output logic             serOut,
  input  logic             serIn,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  output logic             busy
`ifdef SERIAL_PARITY_EN
  ,
  output logic             rxParErr
`endif
);

`ifdef SERIAL_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int F  = LAT + NB;
  localparam int CW = $clog2(F);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] tmr;
  logic [NB-2:0] txBuf;
  logic [NB-1:0] rxBuf;
  logic [NB-1:0] frame;

`ifdef SERIAL_PARITY_EN
  assign frame = {^txData, txData};
`else
  assign frame = txData;
`endif

  // tmr counts down from F-1; frame cycle c corresponds to tmr == F-1-c,
  // so capture window LAT..F-1 is tmr <= NB-1 and the last SHIFT cycle is tmr == LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmr     <= '0;
      txBuf   <= '0;
      rxBuf   <= '0;
      serOut  <= 1'b0;
      rxData  <= '0;
      rxValid <= 1'b0;
      busy    <= 1'b0;
      txReady <= 1'b1;
`ifdef SERIAL_PARITY_EN
      rxParErr <= 1'b0;
`endif
    end else begin
      rxValid <= 1'b0;
      case (state)
        IDLE: begin
          if (txValid && txReady) begin
            serOut  <= frame[0];
            txBuf   <= frame[NB-1:1];
            tmr     <= CW'(F - 1);
            txReady <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          txBuf <= txBuf >> 1;
          if (tmr == CW'(LAT)) begin
            serOut <= 1'b0;
            state  <= DRAIN;
          end else begin
            serOut <= txBuf[0];
          end
          if (tmr <= CW'(NB - 1)) rxBuf <= {serIn, rxBuf[NB-1:1]};
          tmr <= tmr - CW'(1);
        end
        DRAIN: begin
          if (tmr <= CW'(NB - 1)) rxBuf <= {serIn, rxBuf[NB-1:1]};
          if (tmr == '0) state <= DONE;
          else tmr <= tmr - CW'(1);
        end
        DONE: begin
          rxData  <= rxBuf[WIDTH-1:0];
          rxValid <= 1'b1;
`ifdef SERIAL_PARITY_EN
          rxParErr <= ^rxBuf;
`endif
          txReady <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
